// File: rtl/baseball_play_fsm_if.sv
// baseball_play_fsm_if: play-event handshake between the decoder (master) and the game-state engine (slave).
interface baseball_play_fsm_if;
    logic       play_valid;
    logic [2:0] play_code;
    logic       play_ready;
    logic       play_err;
    modport master (output play_valid, play_code, input play_ready, play_err);
    modport slave (input play_valid, play_code, output play_ready, play_err);
endinterface

// File: rtl/baseball_play_fsm.sv
// baseball_play_fsm: game-state engine tracking runners, outs, batting team and inning from play events.
// Define BASEBALL_WALK_EN to build code 5 as a walk; otherwise code 5 is reported as illegal.
module baseball_play_fsm #(
    parameter int unsigned INNINGS = 9
) (
    input  logic                      clk,
    input  logic                      reset_n,
    baseball_play_fsm_if.slave        play,
    output logic                      team_o,
    output logic [2:0]                base_o,
    output logic [3:0]                add_to_score_o,
    output logic [1:0]                outs_o,
    output logic [3:0]                inning_o,
    output logic                      game_over_o
);
    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_e;
    localparam logic [3:0] LAST_INNING = 4'(INNINGS);

    state_e     state_q, state_d;
    logic       team_q, team_d;
    logic [2:0] base_q, base_d;
    logic [3:0] score_q, score_d;
    logic [1:0] outs_q, outs_d;
    logic [3:0] inning_q, inning_d;
    logic       err_q, err_d;
    logic       end_q, end_d;
    logic [3:0] mask;
    logic [2:0] runs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            team_q   <= 1'b0;
            base_q   <= 3'b000;
            score_q  <= 4'b0000;
            outs_q   <= 2'd0;
            inning_q <= 4'd1;
            err_q    <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            team_q   <= team_d;
            base_q   <= base_d;
            score_q  <= score_d;
            outs_q   <= outs_d;
            inning_q <= inning_d;
            err_q    <= err_d;
            end_q    <= end_d;
        end
    end

    // Runs on a hit are the occupied slots of {batter,1st,2nd,3rd} pushed past home.
    always_comb begin
        mask     = (4'b0001 << play.play_code) - 4'b0001;
        runs     = 3'($countones({1'b1, base_q} & mask));
        state_d  = state_q;
        team_d   = team_q;
        base_d   = base_q;
        score_d  = 4'b0000;
        outs_d   = outs_q;
        inning_d = inning_q;
        err_d    = 1'b0;
        end_d    = end_q;
        case (state_q)
            IDLE: if (play.play_valid) begin
                state_d = HOLD;
                case (play.play_code)
                    3'd0: begin
                        if (outs_q != 2'd2) outs_d = outs_q + 2'd1;
                        else begin
                            outs_d = 2'd0;
                            base_d = 3'b000;
                            if (!team_q) team_d = 1'b1;
                            else if (inning_q == LAST_INNING) end_d = 1'b1;
                            else begin
                                team_d   = 1'b0;
                                inning_d = inning_q + 4'd1;
                            end
                        end
                    end
                    3'd1, 3'd2, 3'd3, 3'd4: begin
                        base_d  = 3'({1'b1, base_q} >> play.play_code);
                        score_d = 4'((5'b00001 << runs) >> 1);
                    end
`ifdef BASEBALL_WALK_EN
                    3'd5: begin
                        base_d  = {1'b1, base_q[2] | base_q[1], base_q[0] | (base_q[2] & base_q[1])};
                        score_d = {3'b000, &base_q};
                    end
`endif
                    default: err_d = 1'b1;
                endcase
            end
            HOLD: state_d = end_q ? DONE : IDLE;
            default: state_d = DONE;
        endcase
    end

    assign play.play_ready = (state_q == IDLE);
    assign play.play_err   = err_q;
    assign game_over_o     = (state_q == DONE);
    assign team_o          = team_q;
    assign base_o          = base_q;
    assign add_to_score_o  = score_q;
    assign outs_o          = outs_q;
    assign inning_o        = inning_q;
endmodule

// File: tb/tb_baseball_play_fsm.sv
// tb_baseball_play_fsm: vector table, hand sequences and randomized plays against a runner-level game model.
module tb_baseball_play_fsm;
    localparam int INN = 9;
`ifdef BASEBALL_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       team, game_over;
    logic [2:0] base;
    logic [3:0] score, inning;
    logic [1:0] outs;
    int checks = 0;
    int failures = 0;

    baseball_play_fsm_if play ();
    baseball_play_fsm #(.INNINGS(INN)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .team_o(team), .base_o(base),
        .add_to_score_o(score), .outs_o(outs), .inning_o(inning), .game_over_o(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] code;
        logic [2:0] base;
        logic [3:0] score;
        logic       err;
        logic [1:0] outs;
        logic       team;
        logic [3:0] inning;
    } vec_t;
    vec_t vt [16];

    int h_base, h_score, h_err, h_outs, h_team, h_inning, h_ready;
    int p_score, p_err, p_ready, p_over;

    // Game model: occ[b] is a runner standing on base b (1=first .. 3=third).
    bit [3:1] occ;
    int m_team, m_outs, m_inning;
    bit m_over;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        play.play_valid = 1'b0;
        play.play_code = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        occ = '0; m_team = 0; m_outs = 0; m_inning = 1; m_over = 1'b0;
    endtask

    task automatic do_play(input logic [2:0] code);
        int n = 0;
        @(negedge clk);
        while (!play.play_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!play.play_ready) check("ready_timeout", 0, 1);
        play.play_valid = 1'b1;
        play.play_code = code;
        @(negedge clk);
        play.play_valid = 1'b0;
        play.play_code = 3'($urandom_range(0, 7));
        h_base = base; h_score = score; h_err = play.play_err; h_outs = outs;
        h_team = team; h_inning = inning; h_ready = play.play_ready;
        @(negedge clk);
        p_score = score; p_err = play.play_err; p_ready = play.play_ready; p_over = game_over;
    endtask

    task automatic model_play(input int code, output int runs, output bit err);
        runs = 0;
        err = 1'b0;
        if (code >= 1 && code <= 4) begin
            bit [3:1] nocc;
            nocc = '0;
            for (int b = 3; b >= 1; b--)
                if (occ[b]) begin
                    if (b + code >= 4) runs++;
                    else nocc[b + code] = 1'b1;
                end
            if (code == 4) runs++;
            else nocc[code] = 1'b1;
            occ = nocc;
        end else if (code == 5 && WALK_EN) begin
            if (occ[1] && occ[2] && occ[3]) runs = 1;
            else if (occ[1] && occ[2]) occ[3] = 1'b1;
            else if (occ[1]) occ[2] = 1'b1;
            occ[1] = 1'b1;
        end else if (code == 0) begin
            if (m_outs < 2) m_outs++;
            else begin
                m_outs = 0;
                occ = '0;
                if (m_team == 0) m_team = 1;
                else if (m_inning == INN) m_over = 1'b1;
                else begin
                    m_team = 0;
                    m_inning++;
                end
            end
        end else err = 1'b1;
    endtask

    task automatic check_done_ignores();
        play.play_valid = 1'b1;
        play.play_code = 3'd4;
        repeat (3) @(negedge clk);
        check("done_base", base, 0);
        check("done_score", score, 0);
        check("done_ready", play.play_ready, 0);
        check("done_over", game_over, 1);
        play.play_valid = 1'b0;
    endtask

    initial begin
        int runs;
        bit err;
        vt[0]  = '{3'd1, 3'b100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[1]  = '{3'd1, 3'b110, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[2]  = '{3'd4, 3'b000, 4'b0100, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[3]  = '{3'd1, 3'b100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[4]  = '{3'd1, 3'b110, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[5]  = '{3'd1, 3'b111, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[6]  = '{3'd3, 3'b001, 4'b0100, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[7]  = '{3'd2, 3'b010, 4'b0001, 1'b0, 2'd0, 1'b0, 4'd1};
        vt[8]  = '{3'd7, 3'b010, 4'b0000, 1'b1, 2'd0, 1'b0, 4'd1};
        vt[9]  = '{3'd0, 3'b010, 4'b0000, 1'b0, 2'd1, 1'b0, 4'd1};
        vt[10] = '{3'd6, 3'b010, 4'b0000, 1'b1, 2'd1, 1'b0, 4'd1};
        vt[11] = '{3'd0, 3'b010, 4'b0000, 1'b0, 2'd2, 1'b0, 4'd1};
        vt[12] = '{3'd0, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b1, 4'd1};
        vt[13] = '{3'd0, 3'b000, 4'b0000, 1'b0, 2'd1, 1'b1, 4'd1};
        vt[14] = '{3'd0, 3'b000, 4'b0000, 1'b0, 2'd2, 1'b1, 4'd1};
        vt[15] = '{3'd0, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'd2};

        do_reset();
        check("rst_team", team, 0);
        check("rst_base", base, 0);
        check("rst_score", score, 0);
        check("rst_outs", outs, 0);
        check("rst_inning", inning, 1);
        check("rst_err", play.play_err, 0);
        check("rst_over", game_over, 0);
        check("rst_ready", play.play_ready, 1);

        foreach (vt[i]) begin
            do_play(vt[i].code);
            check($sformatf("vec%0d_base", i), h_base, vt[i].base);
            check($sformatf("vec%0d_score", i), h_score, vt[i].score);
            check($sformatf("vec%0d_err", i), h_err, vt[i].err);
            check($sformatf("vec%0d_outs", i), h_outs, vt[i].outs);
            check($sformatf("vec%0d_team", i), h_team, vt[i].team);
            check($sformatf("vec%0d_inning", i), h_inning, vt[i].inning);
            check($sformatf("vec%0d_hold_ready", i), h_ready, 0);
            check($sformatf("vec%0d_post_score", i), p_score, 0);
            check($sformatf("vec%0d_post_err", i), p_err, 0);
            check($sformatf("vec%0d_post_ready", i), p_ready, 1);
        end

        // Walk with runners on first and second.
        do_reset();
        do_play(3'd1);
        do_play(3'd1);
        do_play(3'd5);
        check("walk1_base", h_base, WALK_EN ? 3'b111 : 3'b110);
        check("walk1_score", h_score, 0);
        check("walk1_err", h_err, WALK_EN ? 0 : 1);
        check("walk1_post_err", p_err, 0);
        do_play(3'd5);
        check("walk2_base", h_base, WALK_EN ? 3'b111 : 3'b110);
        check("walk2_score", h_score, WALK_EN ? 1 : 0);

        // Full game of outs ends at the bottom of the last inning.
        do_reset();
        do_play(3'd1);
        for (int i = 0; i < INN * 6; i++) begin
            do_play(3'd0);
            if (i == INN * 6 - 2) check("pre_end_over", p_over, 0);
        end
        check("end_over", p_over, 1);
        check("end_ready", p_ready, 0);
        check("end_team", team, 1);
        check("end_inning", inning, INN);
        check("end_outs", outs, 0);
        check_done_ignores();

        // Asynchronous reset in the HOLD cycle of a home run.
        do_reset();
        do_play(3'd1);
        do_play(3'd1);
        @(negedge clk);
        play.play_valid = 1'b1;
        play.play_code = 3'd4;
        @(negedge clk);
        play.play_valid = 1'b0;
        check("hr_hold_score", score, 4'b0100);
        reset_n = 1'b0;
        #1;
        check("arst_score", score, 0);
        check("arst_base", base, 0);
        check("arst_team", team, 0);
        check("arst_inning", inning, 1);
        check("arst_ready", play.play_ready, 1);
        check("arst_over", game_over, 0);

        // Randomized plays against the model.
        do_reset();
        for (int k = 0; k < 700; k++) begin
            int r, code;
            r = $urandom_range(0, 11);
            code = (r < 5) ? 0 : r - 4;
            model_play(code, runs, err);
            do_play(3'(code));
            check("rnd_base", h_base, {occ[1], occ[2], occ[3]});
            check("rnd_score", h_score, runs == 0 ? 0 : 1 << (runs - 1));
            check("rnd_err", h_err, err);
            check("rnd_outs", h_outs, m_outs);
            check("rnd_team", h_team, m_team);
            check("rnd_inning", h_inning, m_inning);
            check("rnd_hold_ready", h_ready, 0);
            check("rnd_post_score", p_score, 0);
            check("rnd_post_ready", p_ready, !m_over);
            check("rnd_post_over", p_over, m_over);
            if (m_over) begin
                check_done_ignores();
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
